// File: rtl/mem_responder.sv
// Unified instruction/data word memory for the multicycle datapath.
// One access at a time over a request/ready handshake with fixed latency.
module mem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] adr,
  input  logic [31:0] writeData,
  output logic [31:0] memOut,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam int         DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [1:0]  stateReg, stateNext;
  logic [3:0]  countReg, countNext;
  logic [31:0] adrReg, dataReg;
  logic        rdReg, wrReg, errReg;
  logic [31:0] mem [0:DEPTH-1];

  logic                 enterResp;
  logic [31:0]          accAdr, accData;
  logic                 accRd, accWr, accErr;
  logic [ADDR_BITS-1:0] wordIdx;
  logic                 doWrite, doRead;

  always_comb begin
    stateNext = stateReg;
    countNext = countReg;
    case (stateReg)
      IDLE: begin
        if (memRead | memWrite) begin
          countNext = LAT_M1;
          stateNext = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        countNext = countReg - 4'd1;
        if (countReg == 4'd1) stateNext = RESP;
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // With LATENCY=1 the array is touched on the accept edge itself, so the
  // live request is used instead of the not-yet-latched copy.
  always_comb begin
    if (stateReg == IDLE) begin
      accAdr  = adr;
      accData = writeData;
      accRd   = memRead;
      accWr   = memWrite;
    end else begin
      accAdr  = adrReg;
      accData = dataReg;
      accRd   = rdReg;
      accWr   = wrReg;
    end
  end

  assign enterResp = (stateNext == RESP) && (stateReg != RESP);
  assign accErr    = (accAdr[1:0] != 2'b00) ||
                     (accAdr[31:ADDR_BITS+2] != '0) ||
                     (accRd && accWr);
  assign wordIdx   = accAdr[ADDR_BITS+1:2];
  assign doWrite   = enterResp && !accErr && accWr && !rst;
  assign doRead    = enterResp && !accErr && accRd;

  // Array has no reset; a write coinciding with rst is suppressed above.
  always_ff @(posedge clk) begin
    if (doWrite) mem[wordIdx] <= accData;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= IDLE;
      countReg <= 4'd0;
      adrReg   <= 32'd0;
      dataReg  <= 32'd0;
      rdReg    <= 1'b0;
      wrReg    <= 1'b0;
      errReg   <= 1'b0;
      memOut   <= 32'd0;
    end else begin
      stateReg <= stateNext;
      countReg <= countNext;
      if (stateReg == IDLE && (memRead | memWrite)) begin
        adrReg  <= adr;
        dataReg <= writeData;
        rdReg   <= memRead;
        wrReg   <= memWrite;
      end
      errReg <= enterResp && accErr;
      if (doRead) memOut <= mem[wordIdx];
    end
  end

  assign ready = (stateReg == RESP);
  assign busy  = (stateReg != IDLE);
  assign err   = errReg;

endmodule
